// File: rtl/cmd_uart.sv
// Two-byte command receiver and single-byte response transmitter over 8N1 UART.
// RX assembles {first, second} into cmd; TX shifts out resp on request.
module cmd_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_BUSY = 1'b1;

  // ---------------- receive path ----------------
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          ptr_hi_q, ptr_hi_d;
  logic          byte_ok;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    ptr_hi_d   = ptr_hi_q;
    byte_ok    = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_CNT;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          // A line back high at mid-start-bit was only a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          rx_cnt_d   = FULL_CNT;
          rx_bit_d   = 4'd0;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = FULL_CNT;
          if (rx_bit_q == 4'd7) begin
            rx_state_d = RX_STOP;
            rx_bit_d   = 4'd0;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          byte_ok    = rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // cmd is frozen while a finished command waits for its consumer.
    if (byte_ok && !cmd_rdy_q) begin
      if (ptr_hi_q) begin
        cmd_d[15:8] = rx_shift_q;
        ptr_hi_d    = 1'b0;
      end else begin
        cmd_d[7:0] = rx_shift_q;
        ptr_hi_d   = 1'b1;
        cmd_rdy_d  = 1'b1;
      end
    end
    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      ptr_hi_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      cmd_q      <= 16'h0000;
      cmd_rdy_q  <= 1'b0;
      ptr_hi_q   <= 1'b1;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      ptr_hi_q   <= ptr_hi_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  // ---------------- transmit path ----------------
  logic [0:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          resp_sent_q, resp_sent_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    resp_sent_d = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (send_resp) begin
          tx_state_d = TX_BUSY;
          tx_d       = 1'b0;
          tx_shift_d = {1'b1, resp};
          tx_cnt_d   = FULL_CNT;
          tx_bit_d   = 4'd0;
        end
      end
      TX_BUSY: begin
        // Registered so the pulse lands in the final clock of the stop bit.
        resp_sent_d = (tx_bit_q == 4'd9) && (tx_cnt_q == CW'(1));
        if (tx_cnt_q == '0) begin
          tx_cnt_d = FULL_CNT;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // NOTE: shift registers are reset too, so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 4'd0;
      tx_shift_q  <= 9'h1FF;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX        = tx_q;
  assign resp_sent = resp_sent_q;

endmodule
